// File: rtl/cache_2way_cntrl.sv
// 2-way set-associative cache controller: hit compare, per-set LRU victim,
// dirty write-back (EVICT), pipelined line fill (FILL), pipeline stall.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_2way_cntrl #(
  parameter int ADDR_W         = 16,
  parameter int IDX_W          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LAT        = 2,
  localparam int WB            = $clog2(WORDS_PER_LINE),
  localparam int OFF_W         = WB + 1,
  localparam int TAG_W         = ADDR_W - IDX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  output logic               done,
  output logic               cache_hit,
  output logic               stall,
  output logic               err,
  output logic [1:0]         way_en,
  output logic               way_comp,
  output logic               way_write,
  output logic               way_valid_in,
  output logic               way_dirty_in,
  output logic [IDX_W-1:0]   way_idx,
  output logic [OFF_W-1:0]   way_offset,
  output logic [TAG_W-1:0]   way_tag,
  output logic [15:0]        way_data_in,
  input  logic [1:0]         way_hit,
  input  logic [1:0]         way_valid,
  input  logic [1:0]         way_dirty,
  input  logic [2*TAG_W-1:0] way_tag_out,
  input  logic [31:0]        way_data_out,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_stall
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COMP, EVICT, FILL} state_t;
  state_t state, nxt;

  // latched request (byte bit 0 is always zero for accepted requests)
  logic [ADDR_W-1:1]   addr_q;
  logic [15:0]         din_q;
  logic                op_q;       // 1 = write
  logic                vict_q;
  logic [WB-1:0]       ev_k;
  logic [WB:0]         iss_k;      // MSB set once all words issued
  logic [MEM_LAT:1]    vld_pipe;
  logic [MEM_LAT:1][WB-1:0] word_pipe;
  logic [2**IDX_W-1:0] lru;
  logic [15:0]         data_q;
  logic [15:0]         fill_buf;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [WB-1:0]    word_q;
  assign tag_q  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q  = addr_q[OFF_W +: IDX_W];
  assign word_q = addr_q[1 +: WB];

  logic accept, bad, hit, victim, need_ev, issue, ret, last_ret;
  logic [WB-1:0]    ret_word;
  logic [TAG_W-1:0] vtag;

  assign accept   = (state == IDLE) && (rd ^ wr) && !addr[0];
  assign bad      = (state == IDLE) && (rd | wr) && ((rd & wr) || addr[0]);
  assign hit      = |way_hit;
  assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[idx_q]);
  assign need_ev  = victim ? (way_valid[1] & way_dirty[1]) : (way_valid[0] & way_dirty[0]);
  assign issue    = (state == FILL) && !iss_k[WB] && !mem_stall;
  assign ret      = (state == FILL) && vld_pipe[MEM_LAT];
  assign ret_word = word_pipe[MEM_LAT];
  assign last_ret = ret && (&ret_word);
  assign vtag     = vict_q ? way_tag_out[2*TAG_W-1:TAG_W] : way_tag_out[TAG_W-1:0];

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;

  // next state and all array / memory / pipeline controls
  always_comb begin
    nxt          = state;
    stall        = (state != IDLE);
    done         = 1'b0;
    cache_hit    = 1'b0;
    data_out     = data_q;
    way_en       = 2'b00;
    way_comp     = 1'b0;
    way_write    = 1'b0;
    way_valid_in = 1'b0;
    way_dirty_in = 1'b0;
    way_idx      = '0;
    way_offset   = '0;
    way_tag      = '0;
    way_data_in  = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    case (state)
      IDLE: if (accept) nxt = COMP;
      COMP: begin
        way_en       = 2'b11;
        way_comp     = 1'b1;
        way_write    = op_q;
        way_valid_in = op_q;
        way_dirty_in = op_q;
        way_idx      = idx_q;
        way_offset   = {word_q, 1'b0};
        way_tag      = tag_q;
        way_data_in  = din_q;
        if (hit) begin
          done      = 1'b1;
          cache_hit = 1'b1;
          if (!op_q) data_out = way_hit[0] ? way_data_out[15:0] : way_data_out[31:16];
          nxt       = IDLE;
        end else begin
          nxt = need_ev ? EVICT : FILL;
        end
      end
      EVICT: begin
        // array read is combinational, so the word streams straight to memory
        way_en     = {vict_q, ~vict_q};
        way_idx    = idx_q;
        way_offset = {ev_k, 1'b0};
        mem_wr     = 1'b1;
        mem_wdata  = vict_q ? way_data_out[31:16] : way_data_out[15:0];
        mem_addr   = {vtag, idx_q, ev_k, 1'b0};
        if (!mem_stall && (&ev_k)) nxt = FILL;
      end
      FILL: begin
        if (issue) begin
          mem_rd   = 1'b1;
          mem_addr = {tag_q, idx_q, iss_k[WB-1:0], 1'b0};
        end
        if (ret) begin
          way_en       = {vict_q, ~vict_q};
          way_write    = 1'b1;
          way_valid_in = 1'b1;
          way_tag      = tag_q;
          way_idx      = idx_q;
          way_offset   = {ret_word, 1'b0};
          if (op_q && (ret_word == word_q)) begin
            way_data_in  = din_q;
            way_dirty_in = 1'b1;
          end else begin
            way_data_in  = mem_rdata;
          end
        end
        if (last_ret) begin
          done = 1'b1;
          if (!op_q) data_out = (ret_word == word_q) ? mem_rdata : fill_buf;
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // request latch, beat counters, read-return pipeline, LRU and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      din_q     <= '0;
      op_q      <= 1'b0;
      vict_q    <= 1'b0;
      ev_k      <= '0;
      iss_k     <= '0;
      vld_pipe  <= '0;
      word_pipe <= '0;
      lru       <= '0;
      data_q    <= '0;
      fill_buf  <= '0;
      err       <= 1'b0;
    end else begin
      err          <= bad;
      vld_pipe[1]  <= issue;
      word_pipe[1] <= iss_k[WB-1:0];
      for (int i = 2; i <= MEM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        word_pipe[i] <= word_pipe[i-1];
      end
      if (accept) begin
        addr_q <= addr[ADDR_W-1:1];
        din_q  <= data_in;
        op_q   <= wr;
        ev_k   <= '0;
        iss_k  <= '0;
      end
      if (state == COMP && !hit) vict_q <= victim;
      if (state == EVICT && !mem_stall) ev_k <= ev_k + WB'(1);
      if (issue) iss_k <= iss_k + (WB+1)'(1);
      if (ret && (ret_word == word_q) && !op_q) fill_buf <= mem_rdata;
      if (done && !op_q) data_q <= data_out;
      if (state == COMP && hit) lru[idx_q] <= way_hit[0];
      if (last_ret) lru[idx_q] <= ~vict_q;
    end
  end

`ifdef CACHE_STATS_EN
  // saturating hit / miss counters, one step per completed request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (done) begin
      if (cache_hit && hit_cnt != 16'hFFFF)        hit_cnt  <= hit_cnt + 16'd1;
      else if (!cache_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_2way_cntrl.sv
// Directed bench for cache_2way_cntrl (W=4, MEM_LAT=2) with behavioural
// way arrays and a 2-cycle banked memory. Memory word at byte a = (a>>1)^A500.
module tb_cache_2way_cntrl;
  logic clk = 0, rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic done, cache_hit, stall, err;
  logic [1:0] way_en;
  logic way_comp, way_write, way_valid_in, way_dirty_in;
  logic [7:0] way_idx;
  logic [2:0] way_offset;
  logic [4:0] way_tag;
  logic [15:0] way_data_in;
  logic [1:0] way_hit, way_valid, way_dirty;
  logic [9:0] way_tag_out;
  logic [31:0] way_data_out;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_wr, mem_rd, mem_stall;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_2way_cntrl dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .cache_hit(cache_hit), .stall(stall), .err(err),
    .way_en(way_en), .way_comp(way_comp), .way_write(way_write),
    .way_valid_in(way_valid_in), .way_dirty_in(way_dirty_in), .way_idx(way_idx),
    .way_offset(way_offset), .way_tag(way_tag), .way_data_in(way_data_in),
    .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_tag_out(way_tag_out), .way_data_out(way_data_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---- way array model ----
  logic        aval   [2][256];
  logic        adirty [2][256];
  logic [4:0]  atag   [2][256];
  logic [15:0] adat   [2][256][4];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w]   = way_en[w] & way_comp & aval[w][way_idx] & (atag[w][way_idx] == way_tag);
      way_valid[w] = aval[w][way_idx];
      way_dirty[w] = adirty[w][way_idx];
    end
    way_tag_out  = {atag[1][way_idx], atag[0][way_idx]};
    way_data_out = {adat[1][way_idx][way_offset[2:1]], adat[0][way_idx][way_offset[2:1]]};
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          aval[w][i]   <= 1'b0;
          adirty[w][i] <= 1'b0;
        end
    end else begin
      for (int w = 0; w < 2; w++)
        if (way_en[w] && way_write) begin
          if (way_comp) begin
            if (way_hit[w]) begin
              adat[w][way_idx][way_offset[2:1]] <= way_data_in;
              adirty[w][way_idx] <= way_dirty_in;
            end
          end else begin
            adat[w][way_idx][way_offset[2:1]] <= way_data_in;
            aval[w][way_idx]   <= way_valid_in;
            atag[w][way_idx]   <= way_tag;
            adirty[w][way_idx] <= way_dirty_in;
          end
        end
    end
  end

  // ---- memory model: unwritten words read as (a>>1)^A500 ----
  logic [15:0] mem [32768];
  logic        mwr [32768];
  logic [15:0] p1, p2;
  logic [15:0] rd_log[$], wr_log[$];

  function automatic logic [15:0] fval(input logic [14:0] wa);
    return {1'b0, wa} ^ 16'hA500;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32768; i++) mwr[i] <= 1'b0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      if (mem_rd) begin
        p1 <= mwr[mem_addr[15:1]] ? mem[mem_addr[15:1]] : fval(mem_addr[15:1]);
        rd_log.push_back(mem_addr);
      end else p1 <= '0;
      p2 <= p1;
      if (mem_wr && !mem_stall) begin
        mem[mem_addr[15:1]] <= mem_wdata;
        mwr[mem_addr[15:1]] <= 1'b1;
        wr_log.push_back(mem_addr);
      end
    end
  end
  assign mem_rdata = p2;

  // ---- checking ----
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {14'd0, stall, done, cache_hit, err, way_en, way_comp, way_write,
            mem_wr, mem_rd, data_out, mem_addr, way_idx};
  endfunction

  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic h,
                        output logic [15:0] dq);
    rd_log.delete();
    wr_log.delete();
    @(negedge clk); rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk); rd = 0; wr = 0; lat = 1;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    if (!done) lat = -1;
    h  = cache_hit;
    dq = data_out;
  endtask

  typedef struct {
    logic rd, wr; logic [15:0] addr, din;
    int lat; logic hit; logic [15:0] dout;
    int nrd; logic [15:0] rdb; int nwr; logic [15:0] wrb;
  } vec_t;
  vec_t vt[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic h, ok;
    logic [15:0] dq;

    vt[0] = '{1, 0, 16'h1234, 16'h0000, 7, 0, 16'hAC1A, 4, 16'h1230, 0, 16'h0000};
    vt[1] = '{1, 0, 16'h1234, 16'h0000, 1, 1, 16'hAC1A, 0, 16'h0000, 0, 16'h0000};
    vt[2] = '{1, 0, 16'h1232, 16'h0000, 1, 1, 16'hAC19, 0, 16'h0000, 0, 16'h0000};
    vt[3] = '{0, 1, 16'h0316, 16'hBEEF, 7, 0, 16'hAC19, 4, 16'h0310, 0, 16'h0000};
    vt[4] = '{1, 0, 16'h0B14, 16'h0000, 7, 0, 16'hA08A, 4, 16'h0B10, 0, 16'h0000};
    vt[5] = '{1, 0, 16'h1310, 16'h0000, 11, 0, 16'hAC88, 4, 16'h1310, 4, 16'h0310};
    vt[6] = '{1, 0, 16'h0316, 16'h0000, 7, 0, 16'hBEEF, 4, 16'h0310, 0, 16'h0000};
    vt[7] = '{0, 1, 16'h1314, 16'h1111, 1, 1, 16'hBEEF, 0, 16'h0000, 0, 16'h0000};
    vt[8] = '{1, 0, 16'h1314, 16'h0000, 1, 1, 16'h1111, 0, 16'h0000, 0, 16'h0000};
    vt[9] = '{1, 0, 16'h0316, 16'h0000, 1, 1, 16'hBEEF, 0, 16'h0000, 0, 16'h0000};

    rst = 0; rd = 0; wr = 0; addr = 0; data_in = 0; mem_stall = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1;
    @(negedge clk);
    chk("idle_outs", outs(), 64'd0);

    // main table: miss/hit/write/evict sequence across two sets
    for (int i = 0; i < 10; i++) begin
      do_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].din, lat, h, dq);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_hit", i), h, vt[i].hit);
      chk($sformatf("v%0d_data_out", i), dq, vt[i].dout);
      chk($sformatf("v%0d_n_mem_rd", i), rd_log.size(), vt[i].nrd);
      chk($sformatf("v%0d_n_mem_wr", i), wr_log.size(), vt[i].nwr);
      ok = 1;
      for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== vt[i].rdb + 16'(2*k)) ok = 0;
      for (int k = 0; k < wr_log.size(); k++) if (wr_log[k] !== vt[i].wrb + 16'(2*k)) ok = 0;
      chk($sformatf("v%0d_mem_addrs", i), ok, 1);
    end

    // bad requests: err pulse, nothing accepted
    rd_log.delete(); wr_log.delete();
    @(negedge clk); rd = 1; wr = 1; addr = 16'h1234;
    @(negedge clk);
    chk("err_rdwr", err, 1);
    chk("err_rdwr_idle", {stall, way_en, mem_rd, mem_wr}, 0);
    rd = 0; wr = 0;
    @(negedge clk);
    chk("err_rdwr_pulse", err, 0);
    @(negedge clk); rd = 1; addr = 16'h0001;
    @(negedge clk);
    chk("err_odd", err, 1);
    chk("err_odd_idle", {stall, way_en, mem_rd, mem_wr}, 0);
    rd = 0;
    @(negedge clk);
    chk("err_odd_pulse", {err, done}, 0);
    chk("err_no_mem", rd_log.size() + wr_log.size(), 0);

    // mem_stall for 3 cycles in the middle of FILL issue
    fork
      do_req(1, 0, 16'h4000, 16'h0000, lat, h, dq);
      begin
        int n = 0;
        while (!mem_rd && n < 30) begin @(negedge clk); n++; end
        @(negedge clk); mem_stall = 1;
        repeat (3) @(negedge clk);
        mem_stall = 0;
      end
    join
    chk("stall_latency", lat, 10);
    chk("stall_data", dq, 16'h8500);
    chk("stall_n_mem_rd", rd_log.size(), 4);
    ok = (rd_log.size() == 4);
    for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== 16'h4000 + 16'(2*k)) ok = 0;
    chk("stall_mem_addrs", ok, 1);

    // reset in the middle of a dirty eviction
    rd_log.delete(); wr_log.delete();
    @(negedge clk); rd = 1; addr = 16'h0B10;
    @(negedge clk); rd = 0;
    @(negedge clk);
    chk("evict_beat0", {stall, mem_wr, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h1310, 16'hAC88});
    @(negedge clk);
    chk("evict_beat1", {mem_wr, mem_addr}, {1'b1, 16'h1312});
    rst = 0;
    #1;
    chk("rst_mid_evict_outs", outs(), 64'd0);
    @(negedge clk);
    chk("rst_mid_evict_wr_beats", wr_log.size(), 1);
    chk("rst_hold_outs", outs(), 64'd0);
    rst = 1;
    do_req(1, 0, 16'h1314, 16'h0000, lat, h, dq);
    chk("post_rst_latency", lat, 7);
    chk("post_rst_hit", h, 0);
    chk("post_rst_data", dq, 16'hAC8A);
    chk("post_rst_no_wr", wr_log.size(), 0);

`ifdef CACHE_STATS_EN
    do_req(1, 0, 16'h1314, 16'h0000, lat, h, dq);
    do_req(1, 0, 16'h1310, 16'h0000, lat, h, dq);
    do_req(1, 0, 16'h1316, 16'h0000, lat, h, dq);
    do_req(1, 0, 16'h2000, 16'h0000, lat, h, dq);
    @(negedge clk);
    chk("stats_hit_cnt", hit_cnt, 3);
    chk("stats_miss_cnt", miss_cnt, 2);
    force dut.hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt;
    do_req(1, 0, 16'h2000, 16'h0000, lat, h, dq);
    @(negedge clk);
    chk("stats_hit_sat", hit_cnt, 16'hFFFF);
    chk("stats_miss_hold", miss_cnt, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
